cfh_input_framer: RTL and testbench
===================================

// Module: cfh_input_framer
// PURPOSE
//  Upstream framing stage for the 4-point butterfly stage. Collects a serial stream of 12-bit
//  samples into 4-sample frames and presents each frame in parallel with a valid/ready handshake.
//  A skid slot lets the next frame fill while the current frame waits for the downstream stage.
//  Start-of-frame marker realigns framing; discarded partial frames are counted.
// PARAMETERS
//  DATA_W   12   sample width, bits
//  CNT_W    8    width of drop counter
// PORTS
//  CLK        in   1       clock, rising edge
//  RESET      in   1       asynchronous, active-low reset (asserted at 0)
//  IN_DATA    in   DATA_W  serial sample
//  IN_VALID   in   1       IN_DATA valid
//  IN_SOF     in   1       sample is frame slot 0 (qualified by IN_VALID)
//  IN_READY   out  1       framer accepts a sample this cycle
//  O0..O3     out  DATA_W  frame slots 0..3, to butterfly I0..I3
//  OUT_VALID  out  1       O0..O3 hold a complete frame
//  OUT_READY  in   1       downstream takes frame this cycle
//  DROP_CNT   out  CNT_W   partial frames discarded, saturating
// BEHAVIOUR
//  - Accept = IN_VALID & IN_READY; transfer = OUT_VALID & OUT_READY.
//  - Reset (RESET=0, immediate): O0..O3=0, OUT_VALID=0, DROP_CNT=0, fill index=0, state FILL.
//    Any partial or pending frame is discarded without counting. IN_READY=1 once state is FILL.
//  - States: FILL (slot index 0..3), FULL (4 samples held in fill buffer, output occupied).
//  - IN_READY = (state==FILL), combinational from state only; no dependency on OUT_READY.
//  - FILL, accept, index<3: write sample to slot[index], index++.
//  - FILL, accept, index==3: if output free (!OUT_VALID | OUT_READY) load O0..O2 from slots 0..2
//    and O3 from IN_DATA at this edge, OUT_VALID=1 next cycle, index=0. Else write slot 3, -> FULL.
//  - FULL: on transfer, load O0..O3 from fill buffer, OUT_VALID stays 1, index=0, -> FILL.
//  - Output free and no new frame: transfer clears OUT_VALID.
//  - O0..O3, OUT_VALID stable while OUT_VALID & !OUT_READY.
//  - Latency: last sample accepted at edge k -> frame on O* and OUT_VALID=1 after edge k.
//  - Sustained throughput: 1 sample/cycle with OUT_READY held 1.
//  - SOF: accept with IN_SOF=1 and index!=0 -> partial frame dropped, DROP_CNT+1 (saturate at
//    2^CNT_W-1), sample written to slot 0, index=1. IN_SOF at index 0: no drop. No SOF required;
//    framing free-runs modulo 4.
//  - Samples pass through unmodified; no arithmetic, widths preserved.
// CONFIGURATION
//  CFH_FRAMER_BITREV_EN defined: frames presented in bit-reversed slot order
//    (O0=s0, O1=s2, O2=s1, O3=s3) for decimation-in-time use.
//  Undefined: natural order (Ok = sk). Reordering applied at output load only; timing identical.
// STRUCTURE
//  Shared package cfh_pkg: DATA_W default, frame size constant 4, state enum {FILL, FULL},
//  slot-order constant table (natural / bit-reversed).
//  No sub-module; single flat block (fill buffer, output register, state, counters).
// TESTING
//  1 Reset, OUT_READY=1, stream 1,2,3,4 back-to-back, SOF on 1 -> one cycle after 4th accept
//    O0..O3=1,2,3,4, OUT_VALID=1 for 1 cycle; BITREV build -> 1,3,2,4.
//  2 OUT_READY=0, stream 8 samples 10..17 -> frame 10..13 held, IN_READY=0 after 17 accepted;
//    raise OUT_READY -> 14..17 next cycle, then OUT_VALID=0.
//  3 Samples 5,6 then 7 with IN_SOF=1, then 8,9,10 -> DROP_CNT=1, frame 7,8,9,10.
//  4 Force 300 SOF realignments -> DROP_CNT saturates at 255.
//  5 RESET=0 mid-frame with OUT_VALID=1 -> all outputs 0 immediately, no frame emitted after
//    release until 4 new samples accepted.
//  6 Random IN_VALID/OUT_READY, 10k samples -> scoreboard: frames match input in order, no loss
//    or duplication, outputs stable while stalled.

Source files
------------

// File: rtl/cfh_pkg.sv
// Shared types and constants for the cfh input framer.
// Slot order follows CFH_FRAMER_BITREV_EN (bit-reversed when defined).
package cfh_pkg;

  localparam int DATA_W  = 12;
  localparam int CNT_W   = 8;
  localparam int FRAME_N = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  // Entry k names the fill slot that drives output k.
  localparam logic [3:0][1:0] ORDER_NAT = {
    2'd3, 2'd2, 2'd1, 2'd0
  };
  localparam logic [3:0][1:0] ORDER_REV = {
    2'd3, 2'd1, 2'd2, 2'd0
  };

`ifdef CFH_FRAMER_BITREV_EN
  localparam logic [3:0][1:0] SLOT_ORDER = ORDER_REV;
`else
  localparam logic [3:0][1:0] SLOT_ORDER = ORDER_NAT;
`endif

endpackage

// File: rtl/cfh_input_framer_if.sv
// Serial sample input and parallel frame output of the framer.
// master: upstream/downstream environment; slave: the framer.
interface cfh_input_framer_if #(
  parameter int DATA_W = 12
);

  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_SOF;
  logic              IN_READY;
  logic [DATA_W-1:0] O0;
  logic [DATA_W-1:0] O1;
  logic [DATA_W-1:0] O2;
  logic [DATA_W-1:0] O3;
  logic              OUT_VALID;
  logic              OUT_READY;

  modport master (
    output IN_DATA, IN_VALID, IN_SOF,
    input  IN_READY,
    input  O0, O1, O2, O3, OUT_VALID,
    output OUT_READY
  );

  modport slave (
    input  IN_DATA, IN_VALID, IN_SOF,
    output IN_READY,
    output O0, O1, O2, O3, OUT_VALID,
    input  OUT_READY
  );

endinterface

// File: rtl/cfh_input_framer.sv
// Packs serial 12-bit samples into 4-sample frames with a skid slot.
// Ports: CLK, RESET (async active-low), bus (slave), DROP_CNT.
// Option: CFH_FRAMER_BITREV_EN selects bit-reversed output order.
module cfh_input_framer
  import cfh_pkg::*;
#(
  parameter int DATA_W = cfh_pkg::DATA_W,
  parameter int CNT_W  = cfh_pkg::CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  cfh_input_framer_if.slave bus,
  output logic [CNT_W-1:0] DROP_CNT
);

  typedef logic [FRAME_N-1:0][DATA_W-1:0] frame_t;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  frame_t            slot_q, slot_d;
  frame_t            out_q, out_d;
  logic              ov_q, ov_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic   accept;
  logic   xfer;
  logic   ofree;
  logic   realign;
  logic   fill;
  logic   complete;
  logic   park;
  logic   drain;
  logic   load;
  frame_t frame;

  assign accept = bus.IN_VALID & (state_q == FILL);
  assign xfer   = ov_q & bus.OUT_READY;
  assign ofree  = ~ov_q | bus.OUT_READY;

  // Mutually exclusive actions for this cycle.
  assign realign  = accept & bus.IN_SOF & (idx_q != 2'd0);
  assign fill     = accept & ~realign & (idx_q != 2'd3);
  assign complete = accept & ~realign & (idx_q == 2'd3) & ofree;
  assign park     = accept & ~realign & (idx_q == 2'd3) & ~ofree;
  assign drain    = (state_q == FULL) & xfer;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    slot_d  = slot_q;
    out_d   = out_q;
    ov_d    = ov_q & ~xfer;
    drop_d  = drop_q;
    load    = 1'b0;
    frame   = slot_q;

    unique case (1'b1)
      realign: begin
        if (drop_q != '1) drop_d = drop_q + 1'b1;
        slot_d[0] = bus.IN_DATA;
        idx_d     = 2'd1;
      end
      fill: begin
        slot_d[idx_q] = bus.IN_DATA;
        idx_d         = idx_q + 2'd1;
      end
      complete: begin
        // Last sample bypasses the fill buffer.
        frame    = slot_q;
        frame[3] = bus.IN_DATA;
        load     = 1'b1;
        idx_d    = 2'd0;
      end
      park: begin
        slot_d[3] = bus.IN_DATA;
        state_d   = FULL;
      end
      drain: begin
        load    = 1'b1;
        idx_d   = 2'd0;
        state_d = FILL;
      end
      default: ;
    endcase

    if (load) begin
      for (int k = 0; k < FRAME_N; k++) begin
        out_d[k] = frame[SLOT_ORDER[k]];
      end
      ov_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= FILL;
      idx_q   <= 2'd0;
      slot_q  <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.IN_READY  = (state_q == FILL);
  assign bus.O0        = out_q[0];
  assign bus.O1        = out_q[1];
  assign bus.O2        = out_q[2];
  assign bus.O3        = out_q[3];
  assign bus.OUT_VALID = ov_q;
  assign DROP_CNT      = drop_q;

endmodule

// File: tb/tb_cfh_input_framer.sv
// Directed and scoreboarded checks for cfh_input_framer.
// Honors CFH_FRAMER_BITREV_EN for the expected slot order.
module tb_cfh_input_framer;

  typedef logic [3:0][11:0] frm_t;

  logic       CLK;
  logic       RESET;
  logic [7:0] DROP_CNT;

  int checks   = 0;
  int failures = 0;

  cfh_input_framer_if #(.DATA_W(12)) bus();

  cfh_input_framer #(
    .DATA_W(12),
    .CNT_W (8)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .bus     (bus),
    .DROP_CNT(DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef CFH_FRAMER_BITREV_EN
  int ord [4] = '{0, 2, 1, 3};
`else
  int ord [4] = '{0, 1, 2, 3};
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  function automatic frm_t mk(
    input int a, input int b,
    input int c, input int d
  );
    frm_t f;
    f[0] = a[11:0];
    f[1] = b[11:0];
    f[2] = c[11:0];
    f[3] = d[11:0];
    return f;
  endfunction

  function automatic frm_t cur_o();
    frm_t f;
    f[0] = bus.O0;
    f[1] = bus.O1;
    f[2] = bus.O2;
    f[3] = bus.O3;
    return f;
  endfunction

  task automatic chk_frame(
    input string tag,
    input frm_t  f
  );
    frm_t o;
    o = cur_o();
    chk({tag, "_v"}, bus.OUT_VALID, 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_o%0d", tag, k),
          o[k], f[ord[k]]);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [11:0] d,
    input logic        s,
    input logic        r
  );
    bus.IN_VALID  = v;
    bus.IN_DATA   = d;
    bus.IN_SOF    = s;
    bus.OUT_READY = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = '0;
    bus.IN_SOF    = 1'b0;
    bus.OUT_READY = 1'b0;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  logic [11:0] sbq [$];
  frm_t        saved;
  logic        stalled = 1'b0;
  int          sent    = 0;
  int          frames  = 0;

  task automatic step(
    input logic        v,
    input logic [11:0] d,
    input logic        r
  );
    frm_t o;
    frm_t e;
    o = cur_o();
    if (stalled) begin
      chk("stab_v", bus.OUT_VALID, 1);
      chk("stab_o", o, saved);
    end
    if (bus.OUT_VALID && r) begin
      if (sbq.size() < 4) begin
        chk("sb_under", sbq.size(), 4);
      end else begin
        for (int k = 0; k < 4; k++)
          e[k] = sbq.pop_front();
        for (int k = 0; k < 4; k++)
          chk("sb_o", o[k], e[ord[k]]);
        frames++;
      end
    end
    stalled = bus.OUT_VALID && !r;
    saved   = o;
    if (v && bus.IN_READY) begin
      sbq.push_back(d);
      sent++;
    end
    drive(v, d, 1'b0, r);
  endtask

  initial begin
    RESET = 1'b1;
    do_reset();

    // Reset state
    chk("rst_v",  bus.OUT_VALID, 0);
    chk("rst_o",  cur_o(), 0);
    chk("rst_dc", DROP_CNT, 0);
    chk("rst_ir", bus.IN_READY, 1);

    // 1: back-to-back frame
    drive(1, 12'd1, 1, 1);
    drive(1, 12'd2, 0, 1);
    drive(1, 12'd3, 0, 1);
    chk("t1_nov", bus.OUT_VALID, 0);
    drive(1, 12'd4, 0, 1);
    chk_frame("t1", mk(1, 2, 3, 4));
    chk("t1_dc", DROP_CNT, 0);
    drive(0, 12'd0, 0, 1);
    chk("t1_clr", bus.OUT_VALID, 0);

    // 2: backpressure with skid frame
    for (int i = 10; i <= 13; i++)
      drive(1, 12'(i), 0, 0);
    chk_frame("t2a", mk(10, 11, 12, 13));
    for (int i = 14; i <= 16; i++)
      drive(1, 12'(i), 0, 0);
    chk("t2_ir1", bus.IN_READY, 1);
    drive(1, 12'd17, 0, 0);
    chk("t2_ir0", bus.IN_READY, 0);
    chk_frame("t2b", mk(10, 11, 12, 13));
    drive(1, 12'd99, 0, 0);
    chk_frame("t2c", mk(10, 11, 12, 13));
    drive(0, 12'd0, 0, 1);
    chk_frame("t2d", mk(14, 15, 16, 17));
    chk("t2_ir", bus.IN_READY, 1);
    drive(0, 12'd0, 0, 1);
    chk("t2_clr", bus.OUT_VALID, 0);

    // 3: SOF realignment
    drive(1, 12'd5, 0, 1);
    drive(1, 12'd6, 0, 1);
    drive(1, 12'd7, 1, 1);
    chk("t3_dc", DROP_CNT, 1);
    drive(1, 12'd8, 0, 1);
    drive(1, 12'd9, 0, 1);
    drive(1, 12'd10, 0, 1);
    chk_frame("t3", mk(7, 8, 9, 10));
    drive(0, 12'd0, 0, 1);

    // 4: drop counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, 12'(i), 1, 1);
      if (i == 0)   chk("t4_0",   DROP_CNT, 1);
      if (i == 253) chk("t4_253", DROP_CNT, 254);
      if (i == 254) chk("t4_254", DROP_CNT, 255);
    end
    chk("t4_sat", DROP_CNT, 255);
    chk("t4_nov", bus.OUT_VALID, 0);

    // 5: async reset mid-frame
    drive(1, 12'd21, 0, 0);
    drive(1, 12'd22, 0, 0);
    drive(1, 12'd23, 0, 0);
    chk_frame("t5a", mk(299, 21, 22, 23));
    drive(1, 12'd24, 0, 0);
    drive(1, 12'd25, 0, 0);
    #2;
    RESET = 1'b0;
    #1;
    chk("t5_v",  bus.OUT_VALID, 0);
    chk("t5_o",  cur_o(), 0);
    chk("t5_dc", DROP_CNT, 0);
    chk("t5_ir", bus.IN_READY, 1);
    #2;
    RESET = 1'b1;
    drive(1, 12'd31, 0, 1);
    drive(1, 12'd32, 0, 1);
    drive(1, 12'd33, 0, 1);
    chk("t5_nov", bus.OUT_VALID, 0);
    drive(1, 12'd34, 0, 1);
    chk_frame("t5b", mk(31, 32, 33, 34));
    drive(0, 12'd0, 0, 1);

    // 6: random handshakes with scoreboard
    do_reset();
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      step(($urandom % 4) != 0,
           12'($urandom % 4096),
           ($urandom % 3) != 0);
    end
    chk("t6_sent", sent, 10000);
    for (int c = 0; c < 6; c++)
      step(1'b0, 12'd0, 1'b1);
    chk("t6_frames", frames, 2500);
    chk("t6_left", sbq.size(), 0);
    chk("t6_idle", bus.OUT_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
